// File: rtl/mrx_pkg.sv
// Shared types and default widths for the symbol correlator.
package mrx_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam int SIN_COS_WIDTH_DEF = 16;
    localparam int NSIG_DEF          = 8192;
    localparam int NSYMB_DEF         = 8;
    localparam int ACC_WIDTH_DEF     = 48;
    localparam int OUT_WIDTH_DEF     = 32;
    localparam int OUT_SHIFT_DEF     = 16;
    localparam int TX_SYNC_BITS_DEF  = 5;
    localparam int PHASE_WIDTH       = 24;
    localparam int NSYMB_WIDTH       = 16;

endpackage

// File: rtl/corr_sat_trunc.sv
// Scales an accumulator by an arithmetic right shift and narrows it to the output width.
// MRX_CORR_SAT_EN selects saturation; otherwise the result wraps (low bits kept).
module corr_sat_trunc #(
    parameter int IN_W  = 48,
    parameter int OUT_W = 32,
    parameter int SHIFT = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

`ifdef MRX_CORR_SAT_EN
    logic signed [IN_W-1:0]   shifted;
    logic        [IN_W-OUT_W:0] top_bits;

    // In range only when every bit above the output sign bit matches it.
    always_comb begin
        shifted  = din >>> SHIFT;
        top_bits = shifted[IN_W-1:OUT_W-1];
        if (top_bits == '0 || top_bits == '1) begin
            dout = shifted[OUT_W-1:0];
        end else if (shifted[IN_W-1]) begin
            dout = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            dout = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    assign dout = OUT_W'(din >>> SHIFT);
`endif

endmodule

// File: rtl/mrx_symb_corr.sv
// Symbol correlator: accumulates rx*conj(lo) over NSIG samples and emits one I/Q result per symbol.
// Define MRX_CORR_SAT_EN to saturate the scaled result instead of wrapping it.
module mrx_symb_corr
    import mrx_pkg::*;
#(
    parameter int SIN_COS_WIDTH = SIN_COS_WIDTH_DEF,
    parameter int NSIG          = NSIG_DEF,
    parameter int NSYMB         = NSYMB_DEF,
    parameter int ACC_WIDTH     = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH     = OUT_WIDTH_DEF,
    parameter int OUT_SHIFT     = OUT_SHIFT_DEF,
    parameter int TX_SYNC_BITS  = TX_SYNC_BITS_DEF
) (
    input  logic                            clk,
    input  logic                            aresetn,
    input  logic                            srst,
    input  logic                            in_tvalid,
    output logic                            in_tready,
    input  logic signed [SIN_COS_WIDTH-1:0] irx,
    input  logic signed [SIN_COS_WIDTH-1:0] qrx,
    input  logic signed [SIN_COS_WIDTH-1:0] ilo,
    input  logic signed [SIN_COS_WIDTH-1:0] qlo,
    output logic                            out_tvalid,
    input  logic                            out_tready,
    output logic                            out_tlast,
    output logic signed [OUT_WIDTH-1:0]     icorr,
    output logic signed [OUT_WIDTH-1:0]     qcorr,
    output logic [15:0]                     symb_idx,
    output logic                            sync_ready,
    output logic                            dbg_state
);

    localparam int PROD_W = 2 * SIN_COS_WIDTH + 1;

    // Handshakes: a beat moves on a rising clk edge where valid and ready are both high;
    // valid never waits for ready, and in_tready depends only on state and out_tready.

    state_t state_q, state_d;
    logic   stall;
    logic   rdy_q;
    logic   accept;
    logic   xfer;

    logic [PHASE_WIDTH-1:0]  samp_cnt;
    logic [NSYMB_WIDTH-1:0]  symb_cnt;
    logic [TX_SYNC_BITS-1:0] frame_cnt;

    logic                     p_valid;
    logic                     p_last;
    logic signed [PROD_W-1:0] pi_d, pq_d, pi_q, pq_q;

    logic signed [ACC_WIDTH-1:0] acc_i, acc_q, sum_i, sum_q;
    logic signed [OUT_WIDTH-1:0] res_i, res_q;

    // HOLD freezes everything while a result waits; the cycle out_tready rises behaves as ACC.
    // The ACC-side clash term only matters for NSIG=1, where a new result could land on an unread one.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            ST_ACC: begin
                stall = out_tvalid && !out_tready && p_valid && p_last;
                if (out_tvalid && !out_tready) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                stall = !out_tready;
                if (out_tready) state_d = ST_ACC;
            end
            default: state_d = ST_ACC;
        endcase
    end

    assign in_tready  = rdy_q && !stall;
    assign accept     = in_tvalid && in_tready;
    assign xfer       = out_tvalid && out_tready;
    assign sync_ready = &frame_cnt;
    assign dbg_state  = (state_q == ST_HOLD);

    assign pi_d = PROD_W'(irx) * PROD_W'(ilo) + PROD_W'(qrx) * PROD_W'(qlo);
    assign pq_d = PROD_W'(qrx) * PROD_W'(ilo) - PROD_W'(irx) * PROD_W'(qlo);

    assign sum_i = acc_i + ACC_WIDTH'(pi_q);
    assign sum_q = acc_q + ACC_WIDTH'(pq_q);

    corr_sat_trunc #(.IN_W(ACC_WIDTH), .OUT_W(OUT_WIDTH), .SHIFT(OUT_SHIFT)) u_scale_i (
        .din  (sum_i),
        .dout (res_i)
    );

    corr_sat_trunc #(.IN_W(ACC_WIDTH), .OUT_W(OUT_WIDTH), .SHIFT(OUT_SHIFT)) u_scale_q (
        .din  (sum_q),
        .dout (res_q)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_ACC;
            rdy_q      <= 1'b0;
            samp_cnt   <= '0;
            symb_cnt   <= '0;
            frame_cnt  <= '1;
            p_valid    <= 1'b0;
            p_last     <= 1'b0;
            pi_q       <= '0;
            pq_q       <= '0;
            acc_i      <= '0;
            acc_q      <= '0;
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
            icorr      <= '0;
            qcorr      <= '0;
            symb_idx   <= '0;
        end else if (srst) begin
            state_q    <= ST_ACC;
            rdy_q      <= 1'b0;
            samp_cnt   <= '0;
            symb_cnt   <= '0;
            frame_cnt  <= '1;
            p_valid    <= 1'b0;
            p_last     <= 1'b0;
            pi_q       <= '0;
            pq_q       <= '0;
            acc_i      <= '0;
            acc_q      <= '0;
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
            icorr      <= '0;
            qcorr      <= '0;
            symb_idx   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;

            if (xfer) begin
                out_tvalid <= 1'b0;
                if (out_tlast) frame_cnt <= frame_cnt + TX_SYNC_BITS'(1);
            end

            if (!stall) begin
                p_valid <= accept;
                if (accept) begin
                    pi_q   <= pi_d;
                    pq_q   <= pq_d;
                    p_last <= (samp_cnt == PHASE_WIDTH'(NSIG - 1));
                    if (samp_cnt == PHASE_WIDTH'(NSIG - 1)) samp_cnt <= '0;
                    else                                    samp_cnt <= samp_cnt + PHASE_WIDTH'(1);
                end

                // The last product of a symbol goes straight into the result; the next symbol starts from zero.
                if (p_valid) begin
                    if (p_last) begin
                        acc_i      <= '0;
                        acc_q      <= '0;
                        icorr      <= res_i;
                        qcorr      <= res_q;
                        out_tvalid <= 1'b1;
                        out_tlast  <= (symb_cnt == NSYMB_WIDTH'(NSYMB - 1));
                        symb_idx   <= symb_cnt;
                        if (symb_cnt == NSYMB_WIDTH'(NSYMB - 1)) symb_cnt <= '0;
                        else                                     symb_cnt <= symb_cnt + NSYMB_WIDTH'(1);
                    end else begin
                        acc_i <= sum_i;
                        acc_q <= sum_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mrx_symb_corr.sv
// Self-checking bench for mrx_symb_corr: two instances (OUT_SHIFT 16 and 0) share stimulus
// and are checked against a per-symbol sum-of-products reference model.
module tb_mrx_symb_corr;

    localparam int W     = 16;
    localparam int NSIG  = 4;
    localparam int NSYMB = 2;
    localparam int OW    = 32;
    localparam longint MAX_L = 64'sd2147483647;
    localparam longint MIN_L = -64'sd2147483648;

    // ---------------- clock / reset ----------------
    logic clk        = 1'b0;
    logic aresetn    = 1'b1;
    logic srst       = 1'b0;
    logic in_tvalid  = 1'b0;
    logic out_tready = 1'b0;
    logic signed [W-1:0] irx = '0, qrx = '0, ilo = '0, qlo = '0;

    logic                 in_tready, out_tvalid, out_tlast, sync_ready, dbg_state;
    logic signed [OW-1:0] icorr, qcorr;
    logic [15:0]          symb_idx;
    logic                 in_tready_s, out_tvalid_s, out_tlast_s, sync_ready_s, dbg_state_s;
    logic signed [OW-1:0] icorr_s, qcorr_s;
    logic [15:0]          symb_idx_s;

    always #5 clk = ~clk;

    mrx_symb_corr #(.NSIG(NSIG), .NSYMB(NSYMB), .OUT_SHIFT(16)) dut (
        .clk(clk), .aresetn(aresetn), .srst(srst),
        .in_tvalid(in_tvalid), .in_tready(in_tready),
        .irx(irx), .qrx(qrx), .ilo(ilo), .qlo(qlo),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
        .icorr(icorr), .qcorr(qcorr), .symb_idx(symb_idx),
        .sync_ready(sync_ready), .dbg_state(dbg_state)
    );

    mrx_symb_corr #(.NSIG(NSIG), .NSYMB(NSYMB), .OUT_SHIFT(0)) dut_s (
        .clk(clk), .aresetn(aresetn), .srst(srst),
        .in_tvalid(in_tvalid), .in_tready(in_tready_s),
        .irx(irx), .qrx(qrx), .ilo(ilo), .qlo(qlo),
        .out_tvalid(out_tvalid_s), .out_tready(out_tready), .out_tlast(out_tlast_s),
        .icorr(icorr_s), .qcorr(qcorr_s), .symb_idx(symb_idx_s),
        .sync_ready(sync_ready_s), .dbg_state(dbg_state_s)
    );

    // ---------------- reference model / scoreboard ----------------
    typedef struct packed {
        logic [31:0] i0;
        logic [31:0] q0;
        logic [31:0] i1;
        logic [31:0] q1;
        logic [15:0] idx;
        logic        last;
    } exp_t;

    exp_t   exp_q[$];
    longint sum_i = 0, sum_q = 0;
    int     n_acc = 0, sym_n = 0, frame_n = 31;
    int     n_checks = 0, n_pass = 0;

    function automatic logic [31:0] scale(input longint s, input int sh);
        longint v;
        v = s >>> sh;
`ifdef MRX_CORR_SAT_EN
        if (v > MAX_L) v = MAX_L;
        else if (v < MIN_L) v = MIN_L;
`endif
        return v[31:0];
    endfunction

    task automatic model_reset();
        exp_q.delete();
        sum_i = 0; sum_q = 0; n_acc = 0; sym_n = 0; frame_n = 31;
    endtask

    task automatic model_accept();
        exp_t e;
        sum_i += longint'(irx) * longint'(ilo) + longint'(qrx) * longint'(qlo);
        sum_q += longint'(qrx) * longint'(ilo) - longint'(irx) * longint'(qlo);
        n_acc++;
        if (n_acc == NSIG) begin
            e.i0 = scale(sum_i, 16);
            e.q0 = scale(sum_q, 16);
            e.i1 = scale(sum_i, 0);
            e.q1 = scale(sum_q, 0);
            e.idx  = 16'(sym_n);
            e.last = (sym_n == NSYMB - 1);
            exp_q.push_back(e);
            sym_n = (sym_n + 1) % NSYMB;
            sum_i = 0; sum_q = 0; n_acc = 0;
        end
    endtask

    always @(negedge clk) begin : scoreboard
        exp_t e;
        logic sr_exp;
        if (!aresetn || srst) begin
            model_reset();
        end else begin
            if (out_tvalid && out_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL out_unexpected idx=%0d icorr=%0d required=no output", symb_idx, icorr);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if ({icorr, qcorr, symb_idx, out_tlast} !== {e.i0, e.q0, e.idx, e.last})
                        $display("FAIL result actual=(%0d,%0d,idx%0d,last%0b) required=(%0d,%0d,idx%0d,last%0b)",
                                 icorr, qcorr, symb_idx, out_tlast,
                                 $signed(e.i0), $signed(e.q0), e.idx, e.last);
                    else n_pass++;
                    n_checks++;
                    if ({icorr_s, qcorr_s, symb_idx_s, out_tlast_s, out_tvalid_s} !== {e.i1, e.q1, e.idx, e.last, 1'b1})
                        $display("FAIL result_shift0 actual=(%0d,%0d,idx%0d,v%0b) required=(%0d,%0d,idx%0d,v1)",
                                 icorr_s, qcorr_s, symb_idx_s, out_tvalid_s,
                                 $signed(e.i1), $signed(e.q1), e.idx);
                    else n_pass++;
                    sr_exp = (frame_n == 31);
                    n_checks++;
                    if ({sync_ready, sync_ready_s} !== {sr_exp, sr_exp})
                        $display("FAIL sync_ready actual=%b%b required=%b%b", sync_ready, sync_ready_s, sr_exp, sr_exp);
                    else n_pass++;
                    if (e.last) frame_n = (frame_n + 1) % 32;
                end
            end
            if (in_tvalid && in_tready) model_accept();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_sample(input logic signed [W-1:0] a, b, c, d);
        int t;
        irx = a; qrx = b; ilo = c; qlo = d; in_tvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_tready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!in_tready) begin
            n_checks++;
            $display("FAIL accept_timeout in_tready=%b required=1 within 200 cycles", in_tready);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            t++;
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL drain pending=%0d required=0", exp_q.size());
        else n_pass++;
    endtask

    task automatic wait_out_valid();
        int t;
        t = 0;
        @(negedge clk);
        while (!out_tvalid && t < 100) begin
            t++;
            @(negedge clk);
        end
        n_checks++;
        if (!out_tvalid) $display("FAIL out_valid_timeout out_tvalid=%b required=1", out_tvalid);
        else n_pass++;
    endtask

    task automatic pulse_srst();
        @(posedge clk); #1;
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({in_tready, in_tready_s} !== 2'b00) $display("FAIL reset_in_tready actual=%b%b required=00", in_tready, in_tready_s);
        else n_pass++;
        n_checks++;
        if ({out_tvalid, out_tlast, out_tvalid_s, out_tlast_s} !== 4'b0000)
            $display("FAIL reset_valid_last actual=%b%b%b%b required=0000", out_tvalid, out_tlast, out_tvalid_s, out_tlast_s);
        else n_pass++;
        n_checks++;
        if ({icorr, qcorr, symb_idx} !== '0) $display("FAIL reset_outputs actual=(%0d,%0d,%0d) required=(0,0,0)", icorr, qcorr, symb_idx);
        else n_pass++;
        n_checks++;
        if ({sync_ready, dbg_state} !== 2'b10) $display("FAIL reset_sync_state actual=%b%b required=10", sync_ready, dbg_state);
        else n_pass++;
        aresetn = 1'b1;
        #2;
        n_checks++;
        if (in_tready !== 1'b0) $display("FAIL release_ready_early actual=%b required=0", in_tready);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (in_tready !== 1'b1) $display("FAIL release_ready actual=%b required=1", in_tready);
        else n_pass++;
    endtask

    task automatic test_vectors();
        logic signed [31:0] exp_sat;
        out_tready = 1'b1;
        repeat (NSIG) send_sample(16'sd16384, 16'sd0, 16'sd16384, 16'sd0);
        in_tvalid = 1'b0;
        wait_drain();
        n_checks++;
        if ({icorr, qcorr, symb_idx} !== {32'sd16384, 32'sd0, 16'd0})
            $display("FAIL vec_real actual=(%0d,%0d,%0d) required=(16384,0,0)", icorr, qcorr, symb_idx);
        else n_pass++;

        repeat (NSIG) send_sample(16'sd16384, 16'sd0, 16'sd0, 16'sd16384);
        in_tvalid = 1'b0;
        wait_drain();
        n_checks++;
        if ({icorr, qcorr, symb_idx, out_tlast} !== {32'sd0, -32'sd16384, 16'd1, 1'b1})
            $display("FAIL vec_quad actual=(%0d,%0d,%0d,%b) required=(0,-16384,1,1)", icorr, qcorr, symb_idx, out_tlast);
        else n_pass++;

        repeat (NSIG) send_sample(16'sd32767, 16'sd0, 16'sd32767, 16'sd0);
        in_tvalid = 1'b0;
        wait_drain();
`ifdef MRX_CORR_SAT_EN
        exp_sat = 32'sd2147483647;
`else
        exp_sat = -32'sd262140;
`endif
        n_checks++;
        if (icorr_s !== exp_sat) $display("FAIL vec_fullscale actual=%0d required=%0d", icorr_s, exp_sat);
        else n_pass++;
    endtask

    task automatic test_frame();
        pulse_srst();
        out_tready = 1'b1;
        n_checks++;
        if (sync_ready !== 1'b1) $display("FAIL frame_sync_before actual=%b required=1", sync_ready);
        else n_pass++;
        for (int i = 0; i < NSIG * NSYMB; i++)
            send_sample(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        in_tvalid = 1'b0;
        wait_drain();
        n_checks++;
        if ({sync_ready, symb_idx, out_tlast} !== {1'b0, 16'd1, 1'b1})
            $display("FAIL frame_end actual=(sync%b,idx%0d,last%b) required=(sync0,idx1,last1)", sync_ready, symb_idx, out_tlast);
        else n_pass++;
    endtask

    task automatic test_back_to_back_hold();
        logic [80:0] cap;
        out_tready = 1'b0;
        fork
            begin
                for (int i = 0; i < 2 * NSIG; i++)
                    send_sample(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
                in_tvalid = 1'b0;
            end
            begin
                wait_out_valid();
                cap = {icorr, qcorr, symb_idx, out_tlast};
                repeat (10) begin
                    @(negedge clk);
                    n_checks++;
                    if ({in_tready, out_tvalid, dbg_state, icorr, qcorr, symb_idx, out_tlast} !== {3'b011, cap})
                        $display("FAIL hold_stable actual=(rdy%b,v%b,st%b,%0d,%0d) required=(rdy0,v1,st1,%0d,%0d)",
                                 in_tready, out_tvalid, dbg_state, icorr, qcorr,
                                 $signed(cap[80:49]), $signed(cap[48:17]));
                    else n_pass++;
                end
                @(posedge clk); #1;
                out_tready = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_random();
        bit rnd_on;
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    out_tready = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int i = 0; i < 10 * NSIG; i++) begin
                    send_sample(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
                    in_tvalid = 1'b0;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
                rnd_on = 1'b0;
            end
        join
        out_tready = 1'b1;
        wait_drain();
    endtask

    task automatic test_srst_hold();
        out_tready = 1'b0;
        repeat (NSIG) send_sample(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        in_tvalid = 1'b0;
        wait_out_valid();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({dbg_state, dbg_state_s, in_tready, in_tready_s} !== 4'b1100)
            $display("FAIL srst_hold_state actual=%b%b%b%b required=1100", dbg_state, dbg_state_s, in_tready, in_tready_s);
        else n_pass++;
        pulse_srst();
        n_checks++;
        if ({out_tvalid, dbg_state, sync_ready, icorr, qcorr} !== {3'b001, 64'd0})
            $display("FAIL srst_clear actual=(v%b,st%b,sync%b,%0d,%0d) required=(v0,st0,sync1,0,0)",
                     out_tvalid, dbg_state, sync_ready, icorr, qcorr);
        else n_pass++;
        out_tready = 1'b1;
        repeat (NSIG) send_sample(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        in_tvalid = 1'b0;
        wait_drain();
    endtask

    task automatic test_mid_reset();
        out_tready = 1'b1;
        repeat (2) send_sample(16'sd16384, 16'sd16384, 16'sd16384, 16'sd0);
        in_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b0;
        #2;
        n_checks++;
        if ({out_tvalid, out_tlast, in_tready, icorr, qcorr, symb_idx} !== '0)
            $display("FAIL mid_reset_outputs actual=(v%b,l%b,r%b,%0d,%0d,%0d) required=all zero",
                     out_tvalid, out_tlast, in_tready, icorr, qcorr, symb_idx);
        else n_pass++;
        @(negedge clk);
        @(posedge clk); #1;
        aresetn = 1'b1;
        repeat (NSIG) send_sample(16'sd16384, 16'sd0, 16'sd16384, 16'sd0);
        in_tvalid = 1'b0;
        wait_drain();
        n_checks++;
        if ({icorr, qcorr, symb_idx} !== {32'sd16384, 32'sd0, 16'd0})
            $display("FAIL mid_reset_fresh actual=(%0d,%0d,%0d) required=(16384,0,0)", icorr, qcorr, symb_idx);
        else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_vectors();
        test_frame();
        test_back_to_back_hold();
        test_random();
        test_srst_hold();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached, checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1, "watchdog");
    end

endmodule
